// File: rtl/framebuffer_arbiter.sv
// Frame-buffer RAM arbiter: scan reads take priority, UART writes are queued in a
// small FIFO, and a streak limit guarantees queued writes eventually reach the RAM.
module framebuffer_arbiter #(
  parameter int ADDR_WIDTH      = 11,
  parameter int DATA_WIDTH      = 18,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_SCAN_STREAK = 8
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  scan_req,
  input  logic [ADDR_WIDTH-1:0] scan_addr,
  output logic                  scan_ack,
  output logic                  scan_valid,
  output logic [DATA_WIDTH-1:0] scan_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  wr_overflow,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STK_W = $clog2(MAX_SCAN_STREAK + 1);

  typedef enum logic [1:0] {GRANT_IDLE, GRANT_READ, GRANT_WRITE} grant_t;

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nxt;
  logic [STK_W-1:0]      streak;
  logic                  fifo_empty;
  logic                  streak_full;
  logic                  push;
  logic                  pop;
  logic                  ready_q;
  logic                  overflow_q;
  grant_t                grant;

  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;
  logic                  we_p1;
  logic                  re_p1;
  logic                  vld_p2;

  assign fifo_empty  = (count == '0);
  assign streak_full = (streak == STK_W'(MAX_SCAN_STREAK));

  always_comb begin
    grant = GRANT_IDLE;
    if (!fifo_empty && (!scan_req || streak_full)) begin
      grant = GRANT_WRITE;
    end else if (scan_req) begin
      grant = GRANT_READ;
    end
  end

  assign scan_ack  = (grant == GRANT_READ) && !reset;
  assign push      = wr_req && ready_q && !reset;
  assign pop       = (grant == GRANT_WRITE);
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  // Queue storage carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
      streak     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_nxt;
      ready_q <= (count_nxt < CNT_W'(FIFO_DEPTH));
      if (wr_req && !ready_q) overflow_q <= 1'b1;
      if (pop || fifo_empty) begin
        streak <= '0;
      end else if ((grant == GRANT_READ) && !streak_full) begin
        streak <= streak + STK_W'(1);
      end
    end
  end

  // Stage p1: RAM command registers; address and data hold across idle cycles.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      addr_p1  <= '0;
      wdata_p1 <= '0;
      we_p1    <= 1'b0;
      re_p1    <= 1'b0;
    end else begin
      case (grant)
        GRANT_WRITE: begin
          we_p1    <= 1'b1;
          re_p1    <= 1'b0;
          addr_p1  <= fifo_addr[rd_ptr];
          wdata_p1 <= fifo_data[rd_ptr];
        end
        GRANT_READ: begin
          we_p1   <= 1'b0;
          re_p1   <= 1'b1;
          addr_p1 <= scan_addr;
        end
        default: begin
          we_p1 <= 1'b0;
          re_p1 <= 1'b0;
        end
      endcase
    end
  end

  // Stage p2: RAM returns read data one clock after sampling ram_re.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= re_p1;
    end
  end

  assign ram_addr    = addr_p1;
  assign ram_wdata   = wdata_p1;
  assign ram_we      = we_p1;
  assign ram_re      = re_p1;
  assign scan_valid  = vld_p2;
  assign scan_data   = ram_rdata;
  assign wr_ready    = ready_q;
  assign wr_overflow = overflow_q;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Bench for framebuffer_arbiter: behavioural RAM, queue scoreboards for RAM writes
// and scan read data, plus per-scenario cycle-exact timing checks.
module tb_framebuffer_arbiter;

  localparam int AW = 11;
  localparam int DW = 18;

  logic          clk_in    = 1'b0;
  logic          reset     = 1'b1;
  logic          scan_req  = 1'b0;
  logic [AW-1:0] scan_addr = '0;
  logic          wr_req    = 1'b0;
  logic [AW-1:0] wr_addr   = '0;
  logic [DW-1:0] wr_data   = '0;
  logic [DW-1:0] ram_rdata = '0;
  logic          scan_ack;
  logic          scan_valid;
  logic [DW-1:0] scan_data;
  logic          wr_ready;
  logic          wr_overflow;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          ram_re;
  logic [DW-1:0] ram_wdata;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_wr[$];
  logic [DW-1:0] exp_rd[$];
  wr_t           mon_w;
  logic [DW-1:0] mon_r;
  logic [DW-1:0] ram [2048];
  logic [AW-1:0] next_addr;
  logic          exp_ack;
  int            checks = 0;
  int            errors = 0;

  framebuffer_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .MAX_SCAN_STREAK(8)
  ) dut (
    .clk_in(clk_in), .reset(reset),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_ack(scan_ack),
    .scan_valid(scan_valid), .scan_data(scan_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_overflow(wr_overflow),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk_in = ~clk_in;

  // Reads only target 0x000-0x3FF, writes only 0x600 and up, so read data is fixed.
  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    if (a == 11'h045) return 18'h3F000;
    return {a, a[6:0] ^ 7'h55};
  endfunction

  always @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= ram[ram_addr];
  end

  always @(negedge clk_in) begin
    if (!reset && ram_we) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL ram_write_unexpected got addr=%h data=%h want none", ram_addr, ram_wdata);
      end else begin
        mon_w = exp_wr.pop_front();
        if (ram_addr !== mon_w.a || ram_wdata !== mon_w.d) begin
          errors++;
          $display("FAIL ram_write_order got addr=%h data=%h want addr=%h data=%h",
                   ram_addr, ram_wdata, mon_w.a, mon_w.d);
        end
      end
    end
    if (!reset && scan_valid) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL scan_valid_unexpected got data=%h want none", scan_data);
      end else begin
        mon_r = exp_rd.pop_front();
        if (scan_data !== mon_r) begin
          errors++;
          $display("FAIL scan_read_data got %h want %h", scan_data, mon_r);
        end
      end
    end
  end

  task automatic drain_writes();
    for (int i = 0; i < 20 && exp_wr.size() != 0; i++) @(negedge clk_in);
    checks++;
    if (exp_wr.size() != 0) begin
      errors++;
      $display("FAIL write_drain_timeout got pending=%0d want 0", exp_wr.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; scan_req = 1'b1; scan_addr = 11'h123;
    wr_req = 1'b1; wr_addr = 11'h700; wr_data = 18'h2AAAA;
    repeat (2) @(negedge clk_in);
    checks++; if (scan_ack !== 1'b0) begin errors++; $display("FAIL reset_scan_ack got %b want 0", scan_ack); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
    checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL reset_ram_re got %b want 0", ram_re); end
    checks++; if (ram_addr !== 11'h000) begin errors++; $display("FAIL reset_ram_addr got %h want 000", ram_addr); end
    checks++; if (ram_wdata !== 18'h0) begin errors++; $display("FAIL reset_ram_wdata got %h want 0", ram_wdata); end
    checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL reset_scan_valid got %b want 0", scan_valid); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    checks++; if (wr_overflow !== 1'b0) begin errors++; $display("FAIL reset_wr_overflow got %b want 0", wr_overflow); end
    scan_req = 1'b0; wr_req = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++; if (wr_overflow !== 1'b0) begin errors++; $display("FAIL post_reset_overflow got %b want 0", wr_overflow); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL post_reset_ram_we got %b want 0", ram_we); end
  endtask

  task automatic test_single_read();
    @(posedge clk_in); #1;
    scan_req = 1'b1; scan_addr = 11'h045;
    exp_rd.push_back(18'h3F000);
    @(negedge clk_in);
    checks++; if (scan_ack !== 1'b1) begin errors++; $display("FAIL read_ack got %b want 1", scan_ack); end
    @(posedge clk_in); #1;
    scan_req = 1'b0;
    @(negedge clk_in);
    checks++; if (ram_re !== 1'b1) begin errors++; $display("FAIL read_ram_re got %b want 1", ram_re); end
    checks++; if (ram_addr !== 11'h045) begin errors++; $display("FAIL read_ram_addr got %h want 045", ram_addr); end
    checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL read_valid_early got %b want 0", scan_valid); end
    @(negedge clk_in);
    checks++; if (scan_valid !== 1'b1) begin errors++; $display("FAIL read_valid got %b want 1", scan_valid); end
    checks++; if (scan_data !== 18'h3F000) begin errors++; $display("FAIL read_data got %h want 3f000", scan_data); end
  endtask

  task automatic test_single_write();
    @(posedge clk_in); #1;
    wr_req = 1'b1; wr_addr = 11'h7FF; wr_data = 18'h00FC0;
    exp_wr.push_back('{a: 11'h7FF, d: 18'h00FC0});
    @(negedge clk_in);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL write_ready_c0 got %b want 1", wr_ready); end
    @(posedge clk_in); #1;
    wr_req = 1'b0;
    @(negedge clk_in);
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL write_we_early got %b want 0", ram_we); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL write_ready_c1 got %b want 1", wr_ready); end
    @(negedge clk_in);
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL write_we got %b want 1", ram_we); end
    checks++; if (ram_addr !== 11'h7FF) begin errors++; $display("FAIL write_addr got %h want 7ff", ram_addr); end
    checks++; if (ram_wdata !== 18'h00FC0) begin errors++; $display("FAIL write_data got %h want 00fc0", ram_wdata); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL write_ready_c2 got %b want 1", wr_ready); end
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_streak();
    next_addr = 11'h100;
    for (int c = 0; c <= 11; c++) begin
      @(posedge clk_in); #1;
      scan_req  = 1'b1;
      scan_addr = next_addr;
      wr_req    = (c == 0);
      wr_addr   = 11'h600;
      wr_data   = 18'h12345;
      if (c == 0) exp_wr.push_back('{a: 11'h600, d: 18'h12345});
      @(negedge clk_in);
      exp_ack = (c != 9);
      checks++;
      if (scan_ack !== exp_ack) begin
        errors++; $display("FAIL streak_ack c%0d got %b want %b", c, scan_ack, exp_ack);
      end
      if (exp_ack) begin
        exp_rd.push_back(pix(next_addr));
        next_addr = next_addr + 11'd1;
      end
      if (c == 9) begin
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL streak_we_early got %b want 0", ram_we); end
      end
      if (c == 10) begin
        checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL streak_we got %b want 1", ram_we); end
      end
    end
    @(posedge clk_in); #1;
    scan_req = 1'b0; wr_req = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic test_push_pop_same_cycle();
    next_addr = 11'h140;
    for (int c = 0; c <= 11; c++) begin
      @(posedge clk_in); #1;
      scan_req  = 1'b1;
      scan_addr = next_addr;
      wr_req    = (c <= 2) || (c == 9) || (c == 10);
      wr_addr   = 11'h610 + AW'(c);
      wr_data   = 18'h01000 + DW'(c);
      if (wr_req) exp_wr.push_back('{a: wr_addr, d: wr_data});
      @(negedge clk_in);
      exp_ack = (c != 9);
      checks++;
      if (scan_ack !== exp_ack) begin
        errors++; $display("FAIL pushpop_ack c%0d got %b want %b", c, scan_ack, exp_ack);
      end
      if (exp_ack) begin
        exp_rd.push_back(pix(next_addr));
        next_addr = next_addr + 11'd1;
      end
      if (c == 9 || c == 10) begin
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL pushpop_ready c%0d got %b want 1", c, wr_ready); end
      end
      if (c == 11) begin
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL pushpop_full got %b want 0", wr_ready); end
        checks++; if (wr_overflow !== 1'b0) begin errors++; $display("FAIL pushpop_overflow got %b want 0", wr_overflow); end
      end
    end
    @(posedge clk_in); #1;
    scan_req = 1'b0; wr_req = 1'b0;
    drain_writes();
    repeat (3) @(negedge clk_in);
  endtask

  task automatic test_overflow();
    next_addr = 11'h180;
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk_in); #1;
      scan_req  = 1'b1;
      scan_addr = next_addr;
      wr_req    = (c <= 4);
      wr_addr   = 11'h620 + AW'(c);
      wr_data   = 18'h20000 + DW'(c * 3);
      if (c <= 3) exp_wr.push_back('{a: wr_addr, d: wr_data});
      @(negedge clk_in);
      checks++;
      if (scan_ack !== 1'b1) begin errors++; $display("FAIL ovf_ack c%0d got %b want 1", c, scan_ack); end
      exp_rd.push_back(pix(next_addr));
      next_addr = next_addr + 11'd1;
      if (c <= 3) begin
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready c%0d got %b want 1", c, wr_ready); end
      end
      if (c == 4) begin
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready_low got %b want 0", wr_ready); end
        checks++; if (wr_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", wr_overflow); end
      end
      if (c == 5) begin
        checks++; if (wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", wr_overflow); end
      end
    end
    @(posedge clk_in); #1;
    scan_req = 1'b0; wr_req = 1'b0;
    drain_writes();
    repeat (3) @(negedge clk_in);
    checks++; if (wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", wr_overflow); end
  endtask

  task automatic test_reset_midop();
    next_addr = 11'h1C0;
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk_in); #1;
      scan_req  = 1'b1;
      scan_addr = next_addr;
      wr_req    = (c <= 3);
      wr_addr   = 11'h640 + AW'(c);
      wr_data   = 18'h3A000 + DW'(c);
      @(negedge clk_in);
      checks++;
      if (scan_ack !== 1'b1) begin errors++; $display("FAIL midop_ack c%0d got %b want 1", c, scan_ack); end
      if (c <= 2) exp_rd.push_back(pix(next_addr));
      next_addr = next_addr + 11'd1;
    end
    @(posedge clk_in); #1;
    checks++; if (ram_re !== 1'b1) begin errors++; $display("FAIL midop_re_before got %b want 1", ram_re); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL midop_ready_before got %b want 0", wr_ready); end
    reset = 1'b1;
    #1;
    checks++; if (scan_valid !== 1'b0) begin errors++; $display("FAIL midop_valid got %b want 0", scan_valid); end
    checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL midop_re got %b want 0", ram_re); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL midop_ready got %b want 1", wr_ready); end
    checks++; if (scan_ack !== 1'b0) begin errors++; $display("FAIL midop_ack_reset got %b want 0", scan_ack); end
    checks++; if (wr_overflow !== 1'b0) begin errors++; $display("FAIL midop_overflow got %b want 0", wr_overflow); end
    scan_req = 1'b0; wr_req = 1'b0;
    @(negedge clk_in);
    reset = 1'b0;
    repeat (6) @(negedge clk_in);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = pix(AW'(i));
    test_reset();
    test_single_read();
    test_single_write();
    test_streak();
    test_push_pop_same_cycle();
    test_overflow();
    test_reset_midop();
    checks++;
    if (exp_wr.size() != 0) begin errors++; $display("FAIL pending_writes got %0d want 0", exp_wr.size()); end
    checks++;
    if (exp_rd.size() != 0) begin errors++; $display("FAIL pending_reads got %0d want 0", exp_rd.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
